// File: rtl/adxl362_ctrl_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adxl362_ctrl_defs (package)
// Description : Shared encodings for the ADXL362 SPI master controller:
//               operation codes, FSM state codes, SPI command bytes and
//               small helpers that describe each transaction's byte layout.
// Revision    : 1.0 - initial release
// ============================================================================
package adxl362_ctrl_defs;

   // Command-handshake operation codes
   localparam logic [1:0] OP_WRITE   = 2'd0;
   localparam logic [1:0] OP_READ    = 2'd1;
   localparam logic [1:0] OP_FIFO    = 2'd2;
   localparam logic [1:0] OP_ILLEGAL = 2'd3;

   // Sequencer states
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_CS_SETUP = 3'd1;
   localparam logic [2:0] ST_SHIFT_LO = 3'd2;
   localparam logic [2:0] ST_SHIFT_HI = 3'd3;
   localparam logic [2:0] ST_CS_HOLD  = 3'd4;
   localparam logic [2:0] ST_CS_GAP   = 3'd5;

   // ADXL362 instruction bytes (same values as adxl362_registers.vh)
   localparam logic [7:0] CMD_WRITE_REG = 8'h0A;
   localparam logic [7:0] CMD_READ_REG  = 8'h0B;
   localparam logic [7:0] CMD_READ_FIFO = 8'h0D;

   // Bytes sent before the first returned data byte
   function automatic logic [4:0] hdr_bytes(input logic [1:0] op);
      return (op == OP_FIFO) ? 5'd1 : 5'd2;
   endfunction

   // Byte transmitted at position idx of a transaction; dummy bytes are zero
   function automatic logic [7:0] tx_byte(input logic [1:0] op,
                                          input logic [4:0] idx,
                                          input logic [5:0] addr,
                                          input logic [7:0] wdata);
      logic [7:0] b;
      b = 8'h00;
      if (idx == 5'd0) begin
         case (op)
            OP_WRITE: b = CMD_WRITE_REG;
            OP_READ:  b = CMD_READ_REG;
            OP_FIFO:  b = CMD_READ_FIFO;
            default:  b = 8'h00;
         endcase
      end else if (idx == 5'd1 && op != OP_FIFO) begin
         b = {2'b00, addr};
      end else if (idx == 5'd2 && op == OP_WRITE) begin
         b = wdata;
      end
      return b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/adxl362_spi_shifter.sv
`default_nettype none
// ============================================================================
// Module      : adxl362_spi_shifter
// Description : SCLK half-period divider, 8-bit TX/RX shift registers and
//               bit counter. The sequencer decides when phases end and when
//               a new byte is loaded; this block only times and shifts.
// Revision    : 1.0 - initial release
// Ports       : clk_sys/rst     - clock, synchronous active-high reset
//               div_run         - divider counts while high, clears otherwise
//               byte_start      - load start_byte into TX, bit counter to 7
//               shift           - sample miso into RX, advance TX one bit
//               div_last        - divider at its terminal count
//               last_bit        - bit in flight is the last of the byte
//               mosi            - current TX MSB
//               rx_byte         - byte completed by a shift issued this cycle
// ============================================================================
module adxl362_spi_shifter #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk_sys,
   input  logic       rst,
   input  logic       div_run,
   input  logic       byte_start,
   input  logic [7:0] start_byte,
   input  logic       shift,
   input  logic       miso,
   output logic       div_last,
   output logic       last_bit,
   output logic       mosi,
   output logic [7:0] rx_byte
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic [7:0]       tx_q, tx_d;
   logic [7:0]       rx_q, rx_d;
   logic [2:0]       bit_q, bit_d;

   assign div_last = (div_q == DIV_MAX);
   assign last_bit = (bit_q == 3'd0);
   assign mosi     = tx_q[7];
   assign rx_byte  = {rx_q[6:0], miso};

   always_comb begin
      div_d = '0;
      if (div_run && !div_last) begin
         div_d = div_q + DIV_W'(1);
      end

      tx_d  = tx_q;
      bit_d = bit_q;
      rx_d  = rx_q;
      if (shift) begin
         rx_d  = {rx_q[6:0], miso};
         tx_d  = {tx_q[6:0], 1'b0};
         bit_d = bit_q - 3'd1;
      end
      // A load on the same cycle as the final shift hands over to the next
      // byte without a bubble, so its MSB appears at the falling edge.
      if (byte_start) begin
         tx_d  = start_byte;
         bit_d = 3'd7;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         div_q <= '0;
         tx_q  <= 8'h00;
         rx_q  <= 8'h00;
         bit_q <= 3'd0;
      end else begin
         div_q <= div_d;
         tx_q  <= tx_d;
         rx_q  <= rx_d;
         bit_q <= bit_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/adxl362_spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adxl362_spi_master_ctrl
// Description : SPI mode-0 master and command sequencer for the ADXL362.
//               Runs register write, register burst read and FIFO burst read
//               transactions from a valid/ready command interface and
//               returns read bytes one per rd_valid pulse.
// Revision    : 1.0 - initial release
// Ports       : clk_sys, rst             - clock, sync active-high reset
//               cmd_valid/cmd_ready      - command handshake
//               cmd_op/addr/wdata/len    - command fields
//               rd_data/rd_valid         - returned data bytes
//               done/err                 - end-of-transaction pulse, status
//               busy                     - inverse of cmd_ready
//               SCLK/MOSI/nCS/MISO       - SPI pins
// ============================================================================
module adxl362_spi_master_ctrl
   import adxl362_ctrl_defs::*;
#(
   parameter int CLK_DIV = 4,
   parameter int CS_GAP  = 8
) (
   input  logic       clk_sys,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [5:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   input  logic [3:0] cmd_len,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       done,
   output logic       err,
   output logic       busy,
   output logic       SCLK,
   output logic       MOSI,
   output logic       nCS,
   input  logic       MISO
);

   localparam int GAP_W = (CS_GAP > 2) ? $clog2(CS_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(CS_GAP - 1);

   logic [2:0]       state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [5:0]       addr_q, addr_d;
   logic [7:0]       wdata_q, wdata_d;
   logic [4:0]       total_q, total_d;
   logic [4:0]       byte_idx_q, byte_idx_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             ncs_q, ncs_d;
   logic             sclk_q, sclk_d;
   logic [7:0]       rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             div_run, sh_start, sh_shift;
   logic [7:0]       sh_byte, rx_byte;
   logic             div_last, last_bit, sh_mosi;
   logic [3:0]       len_eff;
   logic [4:0]       next_idx;

   adxl362_spi_shifter #(
      .CLK_DIV (CLK_DIV)
   ) u_shifter (
      .clk_sys    (clk_sys),
      .rst        (rst),
      .div_run    (div_run),
      .byte_start (sh_start),
      .start_byte (sh_byte),
      .shift      (sh_shift),
      .miso       (MISO),
      .div_last   (div_last),
      .last_bit   (last_bit),
      .mosi       (sh_mosi),
      .rx_byte    (rx_byte)
   );

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      total_d    = total_q;
      byte_idx_d = byte_idx_q;
      gap_d      = gap_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      sh_start   = 1'b0;
      sh_byte    = 8'h00;
      sh_shift   = 1'b0;
      len_eff    = (cmd_len == 4'd0) ? 4'd1 : cmd_len;
      next_idx   = byte_idx_q + 5'd1;
      div_run    = (state_q == ST_CS_SETUP) || (state_q == ST_SHIFT_LO) ||
                   (state_q == ST_SHIFT_HI) || (state_q == ST_CS_HOLD);

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               op_d       = cmd_op;
               addr_d     = cmd_addr;
               wdata_d    = cmd_wdata;
               byte_idx_d = 5'd0;
               total_d    = (cmd_op == OP_WRITE) ? 5'd3
                                                 : hdr_bytes(cmd_op) + {1'b0, len_eff};
               if (cmd_op == OP_ILLEGAL) begin
                  // Report immediately, then still honour the inter-command gap
                  state_d = ST_CS_GAP;
                  gap_d   = '0;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  state_d  = ST_CS_SETUP;
                  sh_start = 1'b1;
                  sh_byte  = tx_byte(cmd_op, 5'd0, cmd_addr, cmd_wdata);
               end
            end
         end
         ST_CS_SETUP: begin
            if (div_last) state_d = ST_SHIFT_LO;
         end
         ST_SHIFT_LO: begin
            if (div_last) state_d = ST_SHIFT_HI;
         end
         ST_SHIFT_HI: begin
            if (div_last) begin
               sh_shift = 1'b1;
               state_d  = ST_SHIFT_LO;
               if (last_bit) begin
                  sh_start = 1'b1;
                  if (op_q != OP_WRITE && byte_idx_q >= hdr_bytes(op_q)) begin
                     rd_data_d  = rx_byte;
                     rd_valid_d = 1'b1;
                  end
                  if (byte_idx_q == total_q - 5'd1) begin
                     // Load zero so MOSI rests low after the final byte
                     state_d = ST_CS_HOLD;
                     sh_byte = 8'h00;
                  end else begin
                     byte_idx_d = next_idx;
                     sh_byte    = tx_byte(op_q, next_idx, addr_q, wdata_q);
                  end
               end
            end
         end
         ST_CS_HOLD: begin
            if (div_last) begin
               state_d = ST_CS_GAP;
               gap_d   = '0;
            end
         end
         ST_CS_GAP: begin
            if (gap_q == GAP_MAX) begin
               state_d = ST_IDLE;
               done_d  = (op_q != OP_ILLEGAL);
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Pin levels follow the next state so they change with the state flop
      ncs_d  = !((state_d == ST_CS_SETUP) || (state_d == ST_SHIFT_LO) ||
                 (state_d == ST_SHIFT_HI) || (state_d == ST_CS_HOLD));
      sclk_d = (state_d == ST_SHIFT_HI);
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         op_q       <= OP_WRITE;
         addr_q     <= 6'd0;
         wdata_q    <= 8'h00;
         total_q    <= 5'd0;
         byte_idx_q <= 5'd0;
         gap_q      <= '0;
         ncs_q      <= 1'b1;
         sclk_q     <= 1'b0;
         rd_data_q  <= 8'h00;
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         total_q    <= total_d;
         byte_idx_q <= byte_idx_d;
         gap_q      <= gap_d;
         ncs_q      <= ncs_d;
         sclk_q     <= sclk_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = ~cmd_ready;
   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;
   assign done      = done_q;
   assign err       = err_q;
   assign SCLK      = sclk_q;
   assign MOSI      = sh_mosi;
   assign nCS       = ncs_q;

endmodule
`default_nettype wire

// File: tb/tb_adxl362_spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adxl362_spi_master_ctrl
// Description : Directed bench for adxl362_spi_master_ctrl with a small SPI
//               slave model and a scoreboard for rd_data and done/err.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adxl362_spi_master_ctrl;

   localparam int CLK_DIV = 2;
   localparam int CS_GAP  = 8;
   localparam int LIMIT   = 3000;

   logic       clk_sys = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'd0;
   logic [5:0] cmd_addr = 6'd0;
   logic [7:0] cmd_wdata = 8'h00;
   logic [3:0] cmd_len = 4'd0;
   logic [7:0] rd_data;
   logic       rd_valid, done, err, busy, SCLK, MOSI, nCS;
   logic       MISO = 1'b0;

   always #5 clk_sys = ~clk_sys;

   adxl362_spi_master_ctrl #(
      .CLK_DIV (CLK_DIV),
      .CS_GAP  (CS_GAP)
   ) dut (
      .clk_sys   (clk_sys),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .cmd_len   (cmd_len),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .done      (done),
      .err       (err),
      .busy      (busy),
      .SCLK      (SCLK),
      .MOSI      (MOSI),
      .nCS       (nCS),
      .MISO      (MISO)
   );

   // ---------------- SPI slave model ----------------
   logic [7:0] resp [0:16];
   logic [7:0] s_rx [0:31];
   int         s_bits = 0;
   int         s_nrx = 0;
   int         sclk_txn = 0;
   int         sclk_total = 0;
   logic [7:0] s_sh = 8'h00;

   always @(negedge nCS or posedge SCLK) begin
      logic [7:0] cur;
      if (!SCLK) begin
         s_bits   = 0;
         s_nrx    = 0;
         sclk_txn = 0;
      end else begin
         sclk_total++;
         if (!nCS) begin
            cur = (s_bits / 8 < 17) ? resp[s_bits / 8] : 8'h00;
            MISO = cur[7 - (s_bits % 8)];
            s_sh = {s_sh[6:0], MOSI};
            s_bits++;
            sclk_txn++;
            if (s_bits % 8 == 0 && s_nrx < 32) begin
               s_rx[s_nrx] = s_sh;
               s_nrx++;
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   logic [7:0] exp_rd [0:63];
   logic       exp_err [0:63];
   int         exp_rd_n = 0;
   int         exp_done_n = 0;

   int mon_total = 0, mon_bad = 0;
   int rd_idx = 0, done_idx = 0;
   int ncs_low_txn = 0, ncs_falls = 0, high_run = 0, last_gap = 0;
   logic prev_ncs = 1'b1;

   always @(negedge clk_sys) begin
      if (rd_valid === 1'b1) begin
         mon_total++;
         if (rd_idx >= exp_rd_n) begin
            mon_bad++;
            $display("FAIL rd_unexpected: got rd_data=%02h, none expected", rd_data);
         end else if (rd_data !== exp_rd[rd_idx]) begin
            mon_bad++;
            $display("FAIL rd_data[%0d]: got %02h expected %02h", rd_idx, rd_data, exp_rd[rd_idx]);
         end
         rd_idx++;
      end
      if (done === 1'b1) begin
         mon_total++;
         if (done_idx >= exp_done_n) begin
            mon_bad++;
            $display("FAIL done_unexpected: got done err=%0b, none expected", err);
         end else if (err !== exp_err[done_idx]) begin
            mon_bad++;
            $display("FAIL done_err[%0d]: got %0b expected %0b", done_idx, err, exp_err[done_idx]);
         end
         done_idx++;
      end
      if (nCS === 1'b0) begin
         if (prev_ncs) begin
            ncs_falls++;
            ncs_low_txn = 0;
            last_gap    = high_run;
         end
         ncs_low_txn++;
         high_run = 0;
      end else begin
         high_run++;
      end
      prev_ncs = nCS;
   end

   // ---------------- main stimulus ----------------
   int total = 0, bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push_rd(input logic [7:0] v);
      exp_rd[exp_rd_n] = v;
      exp_rd_n++;
   endtask

   task automatic push_done(input logic e);
      exp_err[exp_done_n] = e;
      exp_done_n++;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (cmd_ready !== 1'b1 && n < LIMIT) begin
         @(negedge clk_sys);
         n++;
      end
      if (n >= LIMIT) begin
         total++;
         bad++;
         $display("FAIL timeout_ready: got cmd_ready=%0b expected 1", cmd_ready);
      end
   endtask

   task automatic send(input logic [1:0] op, input logic [5:0] a,
                       input logic [7:0] wd, input logic [3:0] len);
      wait_ready();
      cmd_op    = op;
      cmd_addr  = a;
      cmd_wdata = wd;
      cmd_len   = len;
      cmd_valid = 1'b1;
      @(negedge clk_sys);
      cmd_valid = 1'b0;
   endtask

   task automatic run(input logic [1:0] op, input logic [5:0] a,
                      input logic [7:0] wd, input logic [3:0] len);
      send(op, a, wd, len);
      wait_ready();
      @(negedge clk_sys);
      #1;
   endtask

   task automatic chk_frame(input string nm, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] b2);
      chk({nm, "_nbytes"}, s_nrx, 3);
      chk({nm, "_mosi0"}, s_rx[0], b0);
      chk({nm, "_mosi1"}, s_rx[1], b1);
      chk({nm, "_mosi2"}, s_rx[2], b2);
      chk({nm, "_sclk_edges"}, sclk_txn, 24);
      chk({nm, "_ncs_low"}, ncs_low_txn, CLK_DIV * (2 + 16 * 3));
   endtask

   initial begin
      int f0, sc0, n;
      for (int i = 0; i < 17; i++) resp[i] = 8'h5A;

      // Reset state
      repeat (3) @(negedge clk_sys);
      chk("rst_ncs", nCS, 1);
      chk("rst_sclk", SCLK, 0);
      chk("rst_mosi", MOSI, 0);
      chk("rst_rd_data", rd_data, 8'h00);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      @(negedge clk_sys);

      // Register write 0x02 -> 0x2D
      push_done(1'b0);
      run(2'd0, 6'h2D, 8'h02, 4'd0);
      chk_frame("wr", 8'h0A, 8'h2D, 8'h02);

      // Register read of DEVID
      resp[2] = 8'hAD;
      push_rd(8'hAD);
      push_done(1'b0);
      run(2'd1, 6'h00, 8'hFF, 4'd1);
      chk_frame("rd", 8'h0B, 8'h00, 8'h00);
      chk("rd_hold", rd_data, 8'hAD);

      // FIFO read of two bytes, low byte first
      resp[1] = 8'h34;
      resp[2] = 8'h12;
      push_rd(8'h34);
      push_rd(8'h12);
      push_done(1'b0);
      run(2'd2, 6'h15, 8'hFF, 4'd2);
      chk_frame("fifo", 8'h0D, 8'h00, 8'h00);

      // Length 0 behaves as a single byte
      resp[1] = 8'h5A;
      resp[2] = 8'hC3;
      push_rd(8'hC3);
      push_done(1'b0);
      run(2'd1, 6'h0F, 8'h00, 4'd0);
      chk_frame("len0", 8'h0B, 8'h0F, 8'h00);

      // Illegal op: done+err on the cycle after accept, pins untouched
      f0  = ncs_falls;
      sc0 = sclk_total;
      push_done(1'b1);
      send(2'd3, 6'h01, 8'h00, 4'd1);
      chk("ill_done", done, 1);
      chk("ill_err", err, 1);
      chk("ill_busy", busy, 1);
      wait_ready();
      chk("ill_ncs_quiet", ncs_falls, f0);
      chk("ill_sclk_quiet", sclk_total, sc0);

      // Back-to-back with cmd_valid held
      resp[2] = 8'hAD;
      push_done(1'b0);
      push_done(1'b0);
      push_rd(8'hAD);
      wait_ready();
      cmd_op = 2'd0; cmd_addr = 6'h1F; cmd_wdata = 8'h55; cmd_len = 4'd0;
      cmd_valid = 1'b1;
      @(negedge clk_sys);
      cmd_op = 2'd1; cmd_addr = 6'h00; cmd_len = 4'd1;
      n = 0;
      while (cmd_ready !== 1'b1 && n < LIMIT) begin @(negedge clk_sys); n++; end
      @(negedge clk_sys);
      cmd_valid = 1'b0;
      chk("b2b_second_accepted", busy, 1);
      wait_ready();
      @(negedge clk_sys);
      #1;
      chk("b2b_gap_min", (last_gap >= CS_GAP) ? 1 : 0, 1);
      chk_frame("b2b_rd", 8'h0B, 8'h00, 8'h00);

      // Pulse on cmd_valid while busy is dropped
      f0 = ncs_falls;
      push_done(1'b0);
      send(2'd0, 6'h2C, 8'h13, 4'd0);
      repeat (20) @(negedge clk_sys);
      chk("drop_busy", busy, 1);
      cmd_op = 2'd1; cmd_addr = 6'h05; cmd_len = 4'd1;
      cmd_valid = 1'b1;
      @(negedge clk_sys);
      cmd_valid = 1'b0;
      wait_ready();
      repeat (40) @(negedge clk_sys);
      #1;
      chk("drop_one_txn", ncs_falls - f0, 1);
      chk_frame("drop_wr", 8'h0A, 8'h2C, 8'h13);

      // Reset during the second byte of a read
      send(2'd1, 6'h02, 8'h00, 4'd2);
      n = 0;
      while (sclk_txn < 10 && n < LIMIT) begin @(negedge clk_sys); n++; end
      if (n >= LIMIT) begin
         total++;
         bad++;
         $display("FAIL timeout_sclk: got sclk_txn=%0d expected 10", sclk_txn);
      end
      rst = 1'b1;
      @(posedge clk_sys);
      #1;
      chk("abort_ncs", nCS, 1);
      chk("abort_sclk", SCLK, 0);
      chk("abort_ready", cmd_ready, 1);
      chk("abort_rd_valid", rd_valid, 0);
      chk("abort_done", done, 0);
      @(negedge clk_sys);
      rst = 1'b0;
      @(negedge clk_sys);
      push_done(1'b0);
      run(2'd0, 6'h2E, 8'hA5, 4'd0);
      chk_frame("post_wr", 8'h0A, 8'h2E, 8'hA5);

      // Every expected response must have been consumed
      repeat (20) @(negedge clk_sys);
      #1;
      chk("sb_rd_count", rd_idx, exp_rd_n);
      chk("sb_done_count", done_idx, exp_done_n);

      total = total + mon_total;
      bad   = bad + mon_bad;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
